// File: rtl/postadder_mc_pkg.sv
// Shared types and constants for the multi-channel redundant-form post-adder.
// Holds the L1 (input) and L3 (stored) limb structs, polynomial typedefs,
// the per-channel mode enum, the modulus split into L3 limbs and the
// L1->L3 / int->L3 conversion helpers.
package PARAMS_postadder_mc;

    localparam int unsigned ADD_DIV    = 4;
    localparam int unsigned LIMB_W     = 64;
    localparam int unsigned IN_CARRY_W = 1;
    localparam int unsigned CARRY_W    = 8;
    localparam int unsigned L3_W       = CARRY_W + LIMB_W;
    localparam int unsigned POLY_W     = ADD_DIV * LIMB_W;

    typedef struct packed {
        logic [IN_CARRY_W-1:0] carry;
        logic [LIMB_W-1:0]     val;
    } l1_limb_t;

    typedef struct packed {
        logic [CARRY_W-1:0] carry;
        logic [LIMB_W-1:0]  val;
    } l3_limb_t;

    // Limb 0 sits in the LSBs.
    typedef l1_limb_t [ADD_DIV-1:0] l1_poly_t;
    typedef l3_limb_t [ADD_DIV-1:0] l3_poly_t;

    typedef enum logic [2:0] {
        MODE_NOP  = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_ACC  = 3'b010,
        MODE_SUBR = 3'b011,
        MODE_RSUB = 3'b100,
        MODE_SUBP = 3'b101,
        MODE_ADDP = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    // BLS12-381 scalar field modulus.
    localparam logic [POLY_W-1:0] MOD = {64'h73eda753299d7d48, 64'h3339d80809a1d805,
                                         64'h53bda402fffe5bfe, 64'hffffffff00000001};

    function automatic l3_limb_t l1_to_l3(input l1_limb_t x);
        l3_limb_t y;
        y.carry = CARRY_W'(x.carry);
        y.val   = x.val;
        return y;
    endfunction

    function automatic l3_poly_t l1p_to_l3p(input l1_poly_t x);
        l3_poly_t y;
        for (int i = 0; i < int'(ADD_DIV); i++) begin
            y[i] = l1_to_l3(x[i]);
        end
        return y;
    endfunction

    function automatic l3_poly_t int_to_l3(input logic [POLY_W-1:0] x);
        l3_poly_t y;
        for (int i = 0; i < int'(ADD_DIV); i++) begin
            y[i].carry = '0;
            y[i].val   = x[i*LIMB_W +: LIMB_W];
        end
        return y;
    endfunction

    localparam l3_poly_t MOD_L3 = int_to_l3(MOD);

endpackage

// File: rtl/postadder_mc_if.sv
// Handshake / data bundle of the post-adder.
// master: drives in_valid, din, mode, addr, thread, out_sel, clr_all;
//         observes in_ready, busy, dout, dout_valid (and ovf).
// slave : the post-adder side.
// Optional: POSTADDER_OVF_CHK_EN adds the sticky ovf flag.
interface postadder_mc_if #(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned THREADS = 4,
    parameter int unsigned DEPTH   = 3
);
    import PARAMS_postadder_mc::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int unsigned SW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                in_valid;
    logic                in_ready;
    l1_poly_t            din;
    logic [N_CH*3-1:0]   mode;
    logic [N_CH*AW-1:0]  addr;
    logic [TW-1:0]       thread;
    logic [SW-1:0]       out_sel;
    logic                clr_all;
    logic                busy;
    l3_poly_t            dout;
    logic                dout_valid;
`ifdef POSTADDER_OVF_CHK_EN
    logic                ovf;
`endif

    modport master (
        output in_valid, din, mode, addr, thread, out_sel, clr_all,
        input  in_ready, busy, dout, dout_valid
`ifdef POSTADDER_OVF_CHK_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, din, mode, addr, thread, out_sel, clr_all,
        output in_ready, busy, dout, dout_valid
`ifdef POSTADDER_OVF_CHK_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/postadder_mc_addsub.sv
// poly_addsub_l3: combinational limb-wise L3 add/sub, no inter-limb carry.
// Ports: a, b (L3 polys), sub (1: a-b, 0: a+b), y_c (result, wraps per limb).
// Optional: POSTADDER_OVF_CHK_EN adds ovf_c, any limb's signed result
// leaving the CARRY_W carry range.
module poly_addsub_l3
    import PARAMS_postadder_mc::*;
(
    input  l3_poly_t a,
    input  l3_poly_t b,
    input  logic     sub,
    output l3_poly_t y_c
`ifdef POSTADDER_OVF_CHK_EN
    , output logic   ovf_c
`endif
);

    logic [L3_W-1:0] res [ADD_DIV];
`ifdef POSTADDER_OVF_CHK_EN
    logic [ADD_DIV-1:0] lovf;
`endif

    for (genvar i = 0; i < int'(ADD_DIV); i++) begin : g_limb
        logic [L3_W-1:0] bop;
        assign bop = sub ? ~b[i] : b[i];
`ifdef POSTADDER_OVF_CHK_EN
        // One guard bit: signed overflow when it disagrees with the MSB.
        logic [L3_W:0] sum;
        assign sum     = {a[i][L3_W-1], a[i]} + {bop[L3_W-1], bop} + (L3_W+1)'(sub);
        assign res[i]  = sum[L3_W-1:0];
        assign lovf[i] = sum[L3_W] ^ sum[L3_W-1];
`else
        assign res[i] = a[i] + bop + L3_W'(sub);
`endif
    end

    always_comb begin
        y_c = '0;
        for (int i = 0; i < int'(ADD_DIV); i++) begin
            y_c[i] = res[i];
        end
    end

`ifdef POSTADDER_OVF_CHK_EN
    assign ovf_c = |lovf;
`endif

endmodule

// File: rtl/postadder_mc.sv
// postadder_mc: N_CH-channel redundant-form post-adder / accumulator.
// Ports: clk, rst (async, active-high), bus (postadder_mc_if.slave):
//   in_valid/in_ready handshake, din, per-channel mode/addr, shared thread,
//   out_sel, clr_all sweep request, busy, dout/dout_valid (OUT_LAT latency).
// Optional: POSTADDER_OVF_CHK_EN adds the sticky bus.ovf flag.
module postadder_mc
    import PARAMS_postadder_mc::*;
#(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned THREADS = 4,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned OUT_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    postadder_mc_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   sw_t_q, sw_t_d;
    logic [AW-1:0]   sw_a_q, sw_a_d;
    logic            fire_c;
    logic            sweep_done_c;

    l3_poly_t        rf [N_CH][THREADS][DEPTH];
    l3_poly_t        in_l3;
    l3_poly_t        z_all [N_CH];
    logic [AW-1:0]   ch_addr [N_CH];
    logic [N_CH-1:0] hit;
    l3_poly_t        last_z [N_CH];
    logic            last_v;
`ifdef POSTADDER_OVF_CHK_EN
    logic [N_CH-1:0] ovf_ch;
    logic            ovf_q;
`endif

    assign fire_c       = bus.in_valid & bus.in_ready;
    assign in_l3        = l1p_to_l3p(bus.din);
    assign sweep_done_c = (state_q == ST_SWEEP) && (sw_a_q == AW'(DEPTH-1))
                          && (sw_t_q == TW'(THREADS-1));

    // Sweep FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sw_t_q  <= '0;
            sw_a_q  <= '0;
        end else begin
            state_q <= state_d;
            sw_t_q  <= sw_t_d;
            sw_a_q  <= sw_a_d;
        end
    end

    // Sweep FSM next state; idx is kept as a (thread, addr) counter pair.
    always_comb begin
        state_d      = state_q;
        sw_t_d       = sw_t_q;
        sw_a_d       = sw_a_q;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = ~bus.clr_all;
                if (bus.clr_all) begin
                    state_d = ST_SWEEP;
                    sw_t_d  = '0;
                    sw_a_d  = '0;
                end
            end
            ST_SWEEP: begin
                bus.busy = 1'b1;
                if (sweep_done_c) begin
                    state_d = ST_IDLE;
                    sw_t_d  = '0;
                    sw_a_d  = '0;
                end else if (sw_a_q == AW'(DEPTH-1)) begin
                    sw_a_d = '0;
                    sw_t_d = sw_t_q + TW'(1);
                end else begin
                    sw_a_d = sw_a_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-channel operand selection and add/sub.
    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        logic [2:0] md;
        l3_poly_t   r, opa, opb;
        logic       sub;

        assign md         = bus.mode[c*3 +: 3];
        assign ch_addr[c] = bus.addr[c*AW +: AW];
        assign hit[c]     = 32'(ch_addr[c]) < DEPTH;
        assign r          = hit[c] ? rf[c][bus.thread][ch_addr[c]] : '0;

        always_comb begin
            opa = '0;
            opb = '0;
            sub = 1'b0;
            case (mode_e'(md))
                MODE_NOP:  opa = r;
                MODE_LOAD: opa = in_l3;
                MODE_ACC:  begin opa = in_l3;  opb = r;              end
                MODE_SUBR: begin opa = in_l3;  opb = r;     sub = 1'b1; end
                MODE_RSUB: begin opa = r;      opb = in_l3; sub = 1'b1; end
                MODE_SUBP: begin opa = MOD_L3; opb = r;     sub = 1'b1; end
                MODE_ADDP: begin opa = r;      opb = MOD_L3;         end
                default:   ;
            endcase
        end

        poly_addsub_l3 u_addsub (
            .a   (opa),
            .b   (opb),
            .sub (sub),
            .y_c (z_all[c])
`ifdef POSTADDER_OVF_CHK_EN
            , .ovf_c (ovf_ch[c])
`endif
        );
    end

    // Register file: sweep clears one entry per cycle, otherwise fire writes Z.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(N_CH); c++)
                for (int t = 0; t < int'(THREADS); t++)
                    for (int d = 0; d < int'(DEPTH); d++)
                        rf[c][t][d] <= '0;
        end else if (state_q == ST_SWEEP) begin
            for (int c = 0; c < int'(N_CH); c++)
                rf[c][sw_t_q][sw_a_q] <= '0;
        end else if (fire_c) begin
            for (int c = 0; c < int'(N_CH); c++)
                if (hit[c]) rf[c][bus.thread][ch_addr[c]] <= z_all[c];
        end
    end

    // Stages 1..OUT_LAT-1 carry all channels; the final stage is dout itself.
    if (OUT_LAT == 1) begin : g_direct
        assign last_v = fire_c;
        for (genvar c = 0; c < int'(N_CH); c++) begin : g_c
            assign last_z[c] = z_all[c];
        end
    end else begin : g_pipe
        l3_poly_t st_z [OUT_LAT-1][N_CH];
        logic     st_v [OUT_LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < int'(OUT_LAT-1); s++) begin
                    st_v[s] <= 1'b0;
                    for (int c = 0; c < int'(N_CH); c++) st_z[s][c] <= '0;
                end
            end else begin
                st_v[0] <= fire_c;
                for (int c = 0; c < int'(N_CH); c++) st_z[0][c] <= z_all[c];
                for (int s = 1; s < int'(OUT_LAT-1); s++) begin
                    st_v[s] <= st_v[s-1];
                    for (int c = 0; c < int'(N_CH); c++) st_z[s][c] <= st_z[s-1][c];
                end
            end
        end

        assign last_v = st_v[OUT_LAT-2];
        for (genvar c = 0; c < int'(N_CH); c++) begin : g_c
            assign last_z[c] = st_z[OUT_LAT-2][c];
        end
    end

    // Output stage: channel select with out_sel sampled here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= last_v;
            bus.dout       <= (32'(bus.out_sel) < N_CH) ? last_z[bus.out_sel] : '0;
        end
    end

`ifdef POSTADDER_OVF_CHK_EN
    // Sticky overflow, cleared when a sweep completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (sweep_done_c) begin
            ovf_q <= 1'b0;
        end else if (fire_c && |(ovf_ch & hit)) begin
            ovf_q <= 1'b1;
        end
    end
    assign bus.ovf = ovf_q;
`endif

endmodule

// File: doc/postadder_mc.md
Name: postadder_mc

Overview:
Parametrised multi-channel, multi-thread redundant-form post-adder/accumulator. It sits after the limb multiplier array.
- Each of N_CH channels owns a THREADS x DEPTH register file of redundant polynomials.
- Each channel performs one per-cycle add/sub/modulus operation between the input and a selected entry.
- One selected channel result leaves through an OUT_LAT-deep output pipeline.
- Adds over the previous generation: a valid/ready handshake, a clear-all sweep FSM, ADDP/CLR modes and a valid-tagged output.

Parameters:
N_CH, 3, number of accumulator channels
THREADS, 4, interleaved threads
DEPTH, 3, entries per thread per channel
ADD_DIV, 4, limbs per polynomial
LIMB_W, 64, limb value width
IN_CARRY_W, 1, carry width of input (L1) limbs
CARRY_W, 8, carry width of stored (L3) limbs
OUT_LAT, 2, cycles from accepted input to dout (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
din  in  ADD_DIV*(IN_CARRY_W+LIMB_W)  L1 redundant polynomial, limb 0 in LSBs, {carry,val} per limb
mode  in  N_CH*3  per-channel opcode
addr  in  N_CH*$clog2(DEPTH)  per-channel entry address
thread  in  $clog2(THREADS)  thread index, shared by all channels
out_sel  in  $clog2(N_CH)  channel routed to dout
clr_all  in  1  pulse: start clear-all sweep
busy  out  1  sweep in progress
dout  out  ADD_DIV*(CARRY_W+LIMB_W)  L3 result
dout_valid  out  1  dout carries a result

Behaviour:
- Reset: all register entries 0, pipeline registers 0, dout=0, dout_valid=0, busy=0, FSM=IDLE.
- Input conversion: each din limb is widened to L3, carry zero-extended to CARRY_W and val copied.
- Limb arithmetic: each limb is a (CARRY_W+LIMB_W)-bit word {carry,val}.
  - Add/sub is limb-wise, with no inter-limb propagation.
  - Results wrap mod 2^(CARRY_W+LIMB_W).
- P is the package modulus split into ADD_DIV limbs with carry=0. R = regfile[ch][thread][addr[ch]].
- Modes per channel:
  - 000 NOP Z=R
  - 001 LOAD Z=IN
  - 010 ACC Z=IN+R
  - 011 SUBR Z=IN-R
  - 100 RSUB Z=R-IN
  - 101 SUBP Z=P-R
  - 110 ADDP Z=R+P
  - 111 CLR Z=0
- Accept: fire = in_valid & in_ready.
  - On fire, every channel writes Z to R's location at the clock edge.
  - Without fire, no regfile writes.
- Address out of range: if addr[ch] >= DEPTH, that channel's write is suppressed and R reads as 0.
- Output pipeline:
  - Stage 1 captures all channel Z with v=fire.
  - The out_sel mux is applied at the last stage using out_sel sampled at that stage.
  - dout/dout_valid appear exactly OUT_LAT cycles after fire.
  - out_sel >= N_CH gives dout=0.
  - The pipeline advances every cycle; there is no backpressure on the output.
- Result visibility: back-to-back fires to the same entry see the previous result (write-then-read next cycle). No forwarding hazard exists.
- FSM:
  - IDLE: in_ready = ~clr_all. clr_all=1 moves to SWEEP with idx=0.
  - SWEEP: busy=1, in_ready=0. Each cycle zeroes entry idx (thread=idx/DEPTH, addr=idx%DEPTH) in all channels. At idx = THREADS*DEPTH-1, return to IDLE.
  - Sweep length is exactly THREADS*DEPTH cycles.
  - clr_all during SWEEP is ignored.
- Simultaneous in_valid and clr_all in IDLE: clr_all wins and the beat is not accepted.
- The output pipeline drains normally during SWEEP.
- rst asserted mid-sweep: immediate return to the reset state.

Optional Feature:
POSTADDER_OVF_CHK_EN
- Defined: adds output port ovf (1 bit), sticky.
  - Set when any written limb's signed carry result overflows CARRY_W.
  - Cleared by rst or by completion of a sweep.
- Undefined: no ovf port and no detection logic.

Decomposition:
- Package PARAMS_postadder_mc holds:
  - the L1/L3 limb structs (parametrised by carry width)
  - the redundant_poly typedefs
  - the mode enum (NOP..CLR)
  - Mod split into limbs
  - the L1-to-L3 and int-to-L3 functions
- One sub-module, poly_addsub_l3: a combinational limb-wise adder with sub input. It is instantiated N_CH times.

Test Plan:
- LOAD then ACC: ch0 LOAD din limbs {0,5}, thread 1, addr 0; then ACC din {0,7} -> second dout = {0,12} in limb 0, dout_valid exactly OUT_LAT cycles after each fire.
- RSUB below zero: R=3, din=5, mode 100 -> limb = 2^(CARRY_W+LIMB_W)-2, i.e. carry all-ones, val all-ones minus 1.
- SUBP/ADDP: R=1 -> SUBP gives P-1 per limb; then ADDP on a zeroed entry gives P.
- Thread isolation: ACC interleaved over threads 0..3, same addr -> each thread holds its own sum; addr>=DEPTH writes nothing.
- Sweep: fill all entries, pulse clr_all with in_valid=1 -> beat not accepted, busy high 12 cycles (4x3), then NOP reads 0 everywhere; rst mid-sweep -> busy=0 next cycle.
- out_sel=3 with N_CH=3 -> dout=0, dout_valid follows fire.
